// File: rtl/alu_result_stage.sv
// Result stage behind the 32-bit ALU: derives the flag vector at capture time, holds up to two
// results in a skid FIFO for writeback, and tracks sticky flags and a committed-op count.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [5:0]       operation,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [5:0]       out_flags,
  output logic [5:0]       out_op,
  input  logic             flags_clr,
  output logic [5:0]       sticky_flags,
  output logic [CNT_W-1:0] op_count
);

  localparam int DEPTH = 2;

  // Flag vector bit positions: {U,P,V,C,N,Z}
  localparam int FZ = 0;
  localparam int FN = 1;
  localparam int FC = 2;
  localparam int FV = 3;
  localparam int FP = 4;
  localparam int FU = 5;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  // FIFO state
  logic [WIDTH-1:0] res_q  [DEPTH];
  logic [5:0]       flg_q  [DEPTH];
  logic [5:0]       op_q   [DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  logic [5:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic push;
  logic pop;

  // in_ready depends only on the stored count, so a pop never frees a slot in the same cycle.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_result   = out_valid ? res_q[rd_ptr_q] : '0;
  assign out_flags    = out_valid ? flg_q[rd_ptr_q] : '0;
  assign out_op       = out_valid ? op_q[rd_ptr_q]  : '0;
  assign sticky_flags = sticky_q;
  assign op_count     = cnt_q;

  // ---------------------------------------------------------------------------
  // Flag derivation on the incoming operation
  // ---------------------------------------------------------------------------
  logic             supported;
  logic [WIDTH-1:0] res_in;
  logic [5:0]       flags_in;
  logic             carry_add;
  logic             carry_add1;
  logic             carry_inc;
  logic             borrow_lt;
  logic             borrow_le;
  logic             a_msb, b_msb, r_msb;

  assign supported = operation inside {6'h00, [6'h02:6'h06], 6'h09, [6'h0D:6'h1D]};
  assign res_in    = supported ? alu_result : '0;

  // Carry out of A+B exists exactly when B exceeds the one's complement of A.
  assign carry_add  = (operandB > ~operandA);
  assign carry_add1 = (operandB >= ~operandA);
  assign carry_inc  = (operandA == ALL_ONES);
  assign borrow_lt  = (operandA < operandB);
  assign borrow_le  = (operandA <= operandB);

  assign a_msb = operandA[WIDTH-1];
  assign b_msb = operandB[WIDTH-1];
  assign r_msb = res_in[WIDTH-1];

  always_comb begin
    flags_in     = '0;
    flags_in[FZ] = (res_in == '0);
    flags_in[FN] = r_msb;
    flags_in[FP] = ~^res_in;
    flags_in[FU] = ~supported;

    unique case (operation)
      6'h00: flags_in[FC] = carry_add;
      6'h02: flags_in[FC] = carry_add1;
      6'h03: flags_in[FC] = carry_inc;
      6'h04: flags_in[FC] = borrow_lt;
      6'h05: flags_in[FC] = borrow_le;
      6'h06: flags_in[FC] = (operandA == '0);
      6'h0D, 6'h1C: flags_in[FC] = a_msb;
      6'h0E, 6'h1D: flags_in[FC] = operandA[0];
      default: flags_in[FC] = 1'b0;
    endcase

    unique case (operation)
      6'h00, 6'h02: flags_in[FV] = (a_msb == b_msb) && (r_msb != a_msb);
      6'h04, 6'h05: flags_in[FV] = (a_msb != b_msb) && (r_msb != a_msb);
      6'h03:        flags_in[FV] = (operandA == MAX_POS);
      6'h06:        flags_in[FV] = (operandA == MIN_NEG);
      6'h0D:        flags_in[FV] = a_msb ^ operandA[WIDTH-2];
      default:      flags_in[FV] = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage entries
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic wr_en;
    assign wr_en = push && (wr_ptr_q == gi[0]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        res_q[gi] <= '0;
        flg_q[gi] <= '0;
        op_q[gi]  <= '0;
      end else if (wr_en) begin
        res_q[gi] <= res_in;
        flg_q[gi] <= flags_in;
        op_q[gi]  <= operation;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy, status
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    // A commit in the same cycle as a clear survives the clear.
    sticky_d = (flags_clr ? 6'd0 : sticky_q) | (pop ? out_flags : 6'd0);
    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: driver queues hand-computed expectations,
// a negedge monitor checks every committed entry in order.
module tb_alu_result_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operandA, operandB, alu_result;
  logic [5:0]  operation;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_flags, out_op;
  logic        flags_clr;
  logic [5:0]  sticky_flags;
  logic [15:0] op_count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [5:0]  flg;
    logic [5:0]  op;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .operandA(operandA), .operandB(operandB), .operation(operation), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_op(out_op),
    .flags_clr(flags_clr), .sticky_flags(sticky_flags), .op_count(op_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every commit is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got result %0h with no entry expected", out_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_result", {32'd0, out_result}, {32'd0, e.res});
        check("out_flags",  {58'd0, out_flags},  {58'd0, e.flg});
        check("out_op",     {58'd0, out_op},     {58'd0, e.op});
      end
    end
  end

  task automatic push(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic [31:0] er, input logic [5:0] ef);
    exp_t e;
    operation = op; operandA = a; operandB = b; alu_result = r;
    in_valid = 1'b1;
    e.res = er; e.flg = ef; e.op = op;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    tests++;
    fails++;
    $display("FAIL push_timeout: in_ready stayed 0 for op %0h", op);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50; t++) begin
      @(posedge clk); #1;
      if (!out_valid && exp_q.size() == 0) return;
    end
    tests++;
    fails++;
    $display("FAIL drain_timeout: out_valid=%0b pending=%0d", out_valid, exp_q.size());
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
    operandA = '0; operandB = '0; operation = '0; alu_result = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_result", {32'd0, out_result}, 64'd0);
    check("rst_out_flags", {58'd0, out_flags}, 64'd0);
    check("rst_out_op",    {58'd0, out_op},    64'd0);
    check("rst_sticky",    {58'd0, sticky_flags}, 64'd0);
    check("rst_op_count",  {48'd0, op_count},  64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD with carry-out, result zero
    push(6'h00, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 6'h15);
    drain();
    check("sticky_after_add", {58'd0, sticky_flags}, 64'h15);
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    check("sticky_cleared", {58'd0, sticky_flags}, 64'h0);

    // SUB with signed overflow
    push(6'h04, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 6'h08);
    drain();
    check("sticky_v_after_sub", {58'd0, sticky_flags}, 64'h08);

    // Mixed opcodes, back-to-back with out_ready high
    push(6'h3F, 32'h1234, 32'h5678, 32'hDEAD_BEEF, 32'h0, 6'h31);
    push(6'h03, 32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 32'h8000_0000, 6'h0A);
    push(6'h02, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 6'h15);
    push(6'h05, 32'h5, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h16);
    push(6'h06, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h16);
    push(6'h0D, 32'h4000_0000, 32'h0, 32'h8000_0000, 32'h8000_0000, 6'h0A);
    push(6'h1D, 32'h1, 32'h0, 32'h0, 32'h0, 6'h15);
    drain();
    check("op_count_after_mixed", {48'd0, op_count}, 64'd9);

    // Backpressure: two accepted, third held until a slot frees
    out_ready = 1'b0;
    push(6'h00, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 6'h15);
    push(6'h04, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 6'h08);
    check("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
    operation = 6'h03; operandA = 32'h7FFF_FFFF; operandB = 32'h0; alu_result = 32'h8000_0000;
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_head_result", {32'd0, out_result}, 64'h0);
    check("bp_head_op", {58'd0, out_op}, 64'h00);
    @(posedge clk); #1;
    check("bp_head_stable", {58'd0, out_op}, 64'h00);
    check("bp_still_full", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_full_during_pop", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    check("bp_ready_after_pop", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    if (in_ready) begin
      exp_t e;
      e.res = 32'h8000_0000; e.flg = 6'h0A; e.op = 6'h03;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Asynchronous reset with two entries held
    out_ready = 1'b0;
    push(6'h09, 32'h0, 32'h0, 32'h1, 32'h1, 6'h00);
    push(6'h09, 32'h0, 32'h0, 32'h2, 32'h2, 6'h00);
    check("pre_rst_full", {63'd0, in_ready}, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("async_rst_op_count",  {48'd0, op_count},  64'd0);
    check("async_rst_sticky",    {58'd0, sticky_flags}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Counter wrap: 65535 commits, then one more alongside a flag clear
    for (int i = 0; i < 65533; i++)
      push(6'h09, 32'h0, 32'h0, 32'h1, 32'h1, 6'h00);
    push(6'h3F, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 6'h31);
    push(6'h05, 32'h5, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h16);
    drain();
    check("op_count_ffff", {48'd0, op_count}, 64'hFFFF);
    check("sticky_before_clr", {58'd0, sticky_flags}, 64'h37);
    out_ready = 1'b0;
    push(6'h0D, 32'h4000_0000, 32'h0, 32'h8000_0000, 32'h8000_0000, 6'h0A);
    out_ready = 1'b1;
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    check("op_count_wrap", {48'd0, op_count}, 64'h0);
    check("sticky_clr_with_commit", {58'd0, sticky_flags}, 64'h0A);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
